// File: rtl/data_cache_pkg.sv
// Shared types and field-width constants for the direct-mapped data cache.
// Holds the miss FSM encoding plus offset/index/tag width helpers.
package data_cache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned WORD_OFF_W = 2;
    localparam int unsigned OFFSET_W   = BYTE_OFF_W + WORD_OFF_W;
    localparam int unsigned DEF_NSETS  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    function automatic int unsigned index_w(input int unsigned nsets);
        return $clog2(nsets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned nsets);
        return ADDR_W - OFFSET_W - $clog2(nsets);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// Main-memory block bus between the data cache (master) and memory (slave).
// Ports: request/write/address/victim data out, fill data and ready pulse in.
interface data_cache_if;

    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous word write or block fill.
// Ports: clk, reset, idx, read outputs, word write and fill write controls.
module dcache_array
    import data_cache_pkg::*;
#(
    parameter int unsigned NSETS  = 8,
    parameter int unsigned IDX_W  = 3,
    parameter int unsigned TAG_W  = 25,
    parameter int unsigned WSEL_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IDX_W-1:0]   idx,
    output logic               valid,
    output logic               dirty,
    output logic [TAG_W-1:0]   tag,
    output logic [BLOCK_W-1:0] data,
    input  logic               word_we,
    input  logic [WSEL_W-1:0]  word_sel,
    input  logic [WORD_W-1:0]  word_data,
    input  logic               fill_we,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_data
);

    logic [NSETS-1:0]   valid_q;
    logic [NSETS-1:0]   valid_d;
    logic [NSETS-1:0]   dirty_q;
    logic [NSETS-1:0]   dirty_d;
    logic [TAG_W-1:0]   tag_q  [NSETS];
    logic [BLOCK_W-1:0] data_q [NSETS];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign data  = data_q[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_we) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end else if (word_we) begin
            dirty_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until valid, so no reset here.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'd0} +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache for the memory stage.
// Ports: CPU load/store side, stall, memory block bus (mem), hit/miss counters.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int unsigned NSETS = DEF_NSETS,
    parameter int unsigned WPB   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    data_cache_if.master mem,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W  = index_w(NSETS);
    localparam int unsigned TAG_W  = tag_w(NSETS);
    localparam int unsigned WSEL_W = $clog2(WPB);

    logic [WSEL_W-1:0] a_word;
    logic [IDX_W-1:0]  a_idx;
    logic [TAG_W-1:0]  a_tag;
    logic [1:0]        unused_byte;

    assign a_word      = addr[BYTE_OFF_W +: WSEL_W];
    assign a_idx       = addr[OFFSET_W +: IDX_W];
    assign a_tag       = addr[ADDR_W-1 -: TAG_W];
    assign unused_byte = addr[1:0];

    state_e            state_q;
    state_e            state_d;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [IDX_W-1:0]  miss_idx_d;
    logic [TAG_W-1:0]  miss_tag_q;
    logic [TAG_W-1:0]  miss_tag_d;
    logic [31:0]       hit_cnt_q;
    logic [31:0]       hit_cnt_d;
    logic [31:0]       miss_cnt_q;
    logic [31:0]       miss_cnt_d;

    logic               access;
    logic               hit;
    logic [IDX_W-1:0]   arr_idx;
    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               word_we;
    logic               fill_we;

    assign access = memread | memwrite;

    // While a miss is outstanding the array looks at the latched miss set,
    // so the memory bus depends only on registered state.
    assign arr_idx = (state_q == IDLE) ? a_idx : miss_idx_q;

    assign hit = (state_q == IDLE) & access & line_valid
               & (line_tag == a_tag);

    dcache_array #(
        .NSETS  (NSETS),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .WSEL_W (WSEL_W)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .idx       (arr_idx),
        .valid     (line_valid),
        .dirty     (line_dirty),
        .tag       (line_tag),
        .data      (line_data),
        .word_we   (word_we),
        .word_sel  (a_word),
        .word_data (writedata),
        .fill_we   (fill_we),
        .fill_tag  (miss_tag_q),
        .fill_data (mem.mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        miss_idx_d    = miss_idx_q;
        miss_tag_d    = miss_tag_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        stall         = 1'b0;
        readdata      = '0;
        word_we       = 1'b0;
        fill_we       = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                        if (memwrite) begin
                            word_we = 1'b1;
                        end else begin
                            readdata = line_data[{a_word, 5'd0} +: WORD_W];
                        end
                    end else begin
                        stall      = 1'b1;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        miss_idx_d = a_idx;
                        miss_tag_d = a_tag;
                        state_d    = (line_valid && line_dirty)
                                   ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {line_tag, miss_idx_q, {OFFSET_W{1'b0}}};
                mem.mem_wdata = line_data;
                if (mem.mem_ready) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall        = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
                if (mem.mem_ready) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // An abandoned transfer must not leave a partial fill or store behind.
        if (reset) begin
            word_we = 1'b0;
            fill_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: random and directed accesses
// checked against a word-level memory model and a set/tag residency model.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        stall;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    data_cache_if mem_if();

    data_cache #(.NSETS(8), .WPB(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memread    (memread),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .stall      (stall),
        .mem        (mem_if),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           we;
        logic [31:0]  a;
        logic [127:0] d;
    } txn_t;

    txn_t txq[$];

    int checks = 0;
    int errors = 0;
    int unstable = 0;

    logic [31:0] phys [int unsigned];
    logic [31:0] arch [int unsigned];

    bit          m_valid [8];
    bit          m_dirty [8];
    logic [24:0] m_tag   [8];
    logic [31:0] exp_hits = 0;
    logic [31:0] exp_misses = 0;

    bit          resp_auto = 1'b1;
    bit          pend = 1'b0;
    int          lat = 0;
    logic [31:0] p_addr;
    bit          p_we;

    function automatic logic [31:0] init_w(input int unsigned wa);
        return wa * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic logic [31:0] rd_phys(input int unsigned wa);
        return phys.exists(wa) ? phys[wa] : init_w(wa);
    endfunction

    function automatic logic [31:0] rd_arch(input int unsigned wa);
        return arch.exists(wa) ? arch[wa] : init_w(wa);
    endfunction

    function automatic logic [127:0] arch_block(input logic [31:0] base);
        logic [127:0] b;
        for (int k = 0; k < 4; k++)
            b[k*32 +: 32] = rd_arch((base >> 2) + k);
        return b;
    endfunction

    // Memory responder: random latency 0..2 extra cycles, one-cycle ready.
    always @(negedge clk) begin
        if (resp_auto) begin
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (mem_if.mem_req) begin
                if (!pend) begin
                    pend   = 1'b1;
                    lat    = $urandom_range(0, 2);
                    p_addr = mem_if.mem_addr;
                    p_we   = mem_if.mem_we;
                end else if (mem_if.mem_addr !== p_addr ||
                             mem_if.mem_we !== p_we) begin
                    unstable++;
                end
                if (lat == 0) begin
                    if (p_we) begin
                        for (int k = 0; k < 4; k++)
                            phys[(p_addr >> 2) + k] = mem_if.mem_wdata[k*32 +: 32];
                    end else begin
                        for (int k = 0; k < 4; k++)
                            mem_if.mem_rdata[k*32 +: 32] = rd_phys((p_addr >> 2) + k);
                    end
                    txq.push_back('{p_we, p_addr, mem_if.mem_wdata});
                    mem_if.mem_ready = 1'b1;
                    pend = 1'b0;
                end else begin
                    lat--;
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        arch = phys;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        memread  = 1'b0;
        memwrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        txq.delete();
    endtask

    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd);
        int unsigned s;
        logic [24:0] t;
        bit          exp_hit;
        bit          exp_wb;
        logic [31:0] vbase;
        logic [127:0] vblk;
        bit          done;
        bit          stalled;
        int          ncyc;
        int          nexp;
        logic [31:0] got;
        s = (a >> 4) & 7;
        t = a[31:7];
        exp_hit = m_valid[s] && (m_tag[s] == t);
        exp_wb  = !exp_hit && m_valid[s] && m_dirty[s];
        vbase   = {m_tag[s], s[2:0], 4'b0};
        vblk    = arch_block(vbase);
        txq.delete();
        @(negedge clk);
        memread   = rd;
        memwrite  = wr;
        addr      = a;
        writedata = wd;
        done    = 1'b0;
        stalled = 1'b0;
        ncyc    = 0;
        got     = '0;
        while (!done && ncyc < 60) begin
            #1;
            if (!stall) begin
                got  = readdata;
                done = 1'b1;
            end else begin
                stalled = 1'b1;
            end
            @(posedge clk);
            ncyc++;
            if (!done) @(negedge clk);
        end
        @(negedge clk);
        memread  = 1'b0;
        memwrite = 1'b0;
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout addr=%h stall still 1 after %0d cycles", a, ncyc);
        end
        if (!exp_hit) begin
            exp_misses++;
            m_valid[s] = 1'b1;
            m_tag[s]   = t;
            m_dirty[s] = 1'b0;
        end
        exp_hits++;
        if (wr) begin
            arch[a >> 2] = wd;
            m_dirty[s]   = 1'b1;
        end
        checks++;
        if (stalled !== !exp_hit) begin
            errors++;
            $display("FAIL stall_seen addr=%h got %0d want %0d", a, stalled, !exp_hit);
        end
        if (rd && !wr) begin
            checks++;
            if (got !== rd_arch(a >> 2)) begin
                errors++;
                $display("FAIL readdata addr=%h got %h want %h", a, got, rd_arch(a >> 2));
            end
        end
        nexp = exp_hit ? 0 : (exp_wb ? 2 : 1);
        checks++;
        if (txq.size() != nexp) begin
            errors++;
            $display("FAIL txn_count addr=%h got %0d want %0d", a, txq.size(), nexp);
        end else if (nexp > 0) begin
            if (exp_wb) begin
                checks++;
                if (txq[0].we !== 1'b1 || txq[0].a !== vbase) begin
                    errors++;
                    $display("FAIL wb_addr got we=%0d a=%h want we=1 a=%h",
                             txq[0].we, txq[0].a, vbase);
                end
                checks++;
                if (txq[0].d !== vblk) begin
                    errors++;
                    $display("FAIL wb_data got %h want %h", txq[0].d, vblk);
                end
            end
            checks++;
            if (txq[nexp-1].we !== 1'b0 || txq[nexp-1].a !== (a & ~32'hF)) begin
                errors++;
                $display("FAIL alloc_addr got we=%0d a=%h want we=0 a=%h",
                         txq[nexp-1].we, txq[nexp-1].a, a & ~32'hF);
            end
        end
        checks++;
        if (hit_count !== exp_hits || miss_count !== exp_misses) begin
            errors++;
            $display("FAIL counters got h=%0d m=%0d want h=%0d m=%0d",
                     hit_count, miss_count, exp_hits, exp_misses);
        end
        checks++;
        if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL idle_bus got req=%0d addr=%h want 0", mem_if.mem_req, mem_if.mem_addr);
        end
    endtask

    task automatic test_reset();
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = '0;
        do_reset();
        #1;
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters got h=%0d m=%0d want 0", hit_count, miss_count);
        end
        checks++;
        if (mem_if.mem_req !== 1'b0 || stall !== 1'b0 || readdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got req=%0d stall=%0d rd=%h want 0",
                     mem_if.mem_req, stall, readdata);
        end
    endtask

    task automatic test_cold_read();
        phys[32'h14 >> 2] = 32'hDEADBEEF;
        arch[32'h14 >> 2] = 32'hDEADBEEF;
        access(1, 0, 32'h0000_0014, 0);
    endtask

    task automatic test_write_hit();
        access(0, 1, 32'h0000_0010, 32'h12345678);
        access(1, 0, 32'h0000_0010, 0);
    endtask

    task automatic test_dirty_evict();
        access(1, 0, 32'h0000_0090, 0);
        checks++;
        if (txq.size() < 1 || txq[0].d[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL evict_word0 got %h want 12345678",
                     (txq.size() > 0) ? txq[0].d[31:0] : 32'hX);
        end
    endtask

    task automatic test_clean_evict();
        bit saw_we;
        access(1, 0, 32'h0000_0110, 0);
        saw_we = 1'b0;
        foreach (txq[i]) if (txq[i].we) saw_we = 1'b1;
        checks++;
        if (saw_we !== 1'b0) begin
            errors++;
            $display("FAIL clean_we got mem_we=1 want never");
        end
    endtask

    task automatic test_idle();
        bit busy;
        busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            memread  = 1'b0;
            memwrite = 1'b0;
            addr     = $urandom;
            #1;
            if (mem_if.mem_req || stall || readdata != 0) busy = 1'b1;
        end
        checks++;
        if (busy || hit_count !== exp_hits || miss_count !== exp_misses) begin
            errors++;
            $display("FAIL idle got busy=%0d h=%0d m=%0d want 0 h=%0d m=%0d",
                     busy, hit_count, miss_count, exp_hits, exp_misses);
        end
        access(1, 0, 32'h0000_0114, 0);
        access(1, 0, 32'h0000_0014, 0);
    endtask

    task automatic test_rw_both();
        access(1, 1, 32'h0000_0118, 32'hA5A5_0001);
        access(1, 0, 32'h0000_0118, 0);
        access(1, 1, 32'h0000_0220, 32'hA5A5_0002);
        access(1, 0, 32'h0000_0220, 0);
    endtask

    task automatic test_mid_miss_reset();
        logic [31:0] a;
        a = 32'h0000_0F24;
        do_reset();
        @(negedge clk);
        resp_auto = 1'b0;
        mem_if.mem_ready = 1'b0;
        memread = 1'b1;
        addr    = a;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL miss_stall got %0d want 1", stall);
        end
        @(negedge clk);
        #1;
        checks++;
        if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0 ||
            mem_if.mem_addr !== 32'h0000_0F20) begin
            errors++;
            $display("FAIL alloc_state got req=%0d we=%0d a=%h want 1 0 00000f20",
                     mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        memread = 1'b0;
        #1;
        checks++;
        if (mem_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_req got %0d want 0", mem_if.mem_req);
        end
        mem_if.mem_rdata = {4{32'hBAD0BAD0}};
        mem_if.mem_ready = 1'b1;
        @(negedge clk);
        mem_if.mem_ready = 1'b0;
        #1;
        checks++;
        if (hit_count !== 0 || miss_count !== 0 || mem_if.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL late_ready got h=%0d m=%0d req=%0d want 0 0 0",
                     hit_count, miss_count, mem_if.mem_req);
        end
        model_reset();
        pend = 1'b0;
        resp_auto = 1'b1;
        access(1, 0, a, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit rd;
        bit wr;
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
              | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            rd = $urandom_range(0, 1);
            wr = !rd || ($urandom_range(0, 7) == 0);
            access(rd, wr, a, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_dirty_evict();
        test_clean_evict();
        test_idle();
        test_rw_both();
        test_mid_miss_reset();
        test_random();
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bus_stable got %0d changes want 0", unstable);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
